// File: rtl/pwm_pkg.sv
// pwm_pkg
// Definitions shared by the 8-bit PWM generator and the PWM decoder: the
// nominal duty-code width, the expected period, the stuck-line timeout and
// the decoder measurement state encoding.
// Ports: none (package).
package pwm_pkg;

  localparam int DUTY_W      = 8;
  localparam int PWM_PERIOD  = 256;
  localparam int PWM_TIMEOUT = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync
// Brings the asynchronous PWM line into the clock domain with a 2-flop
// synchronizer and produces a clean level plus one-cycle edge flags.
// Optional build macro PWM_DEC_GLITCH_FILTER_EN inserts a registered
// 3-sample majority filter after the synchronizer, which rejects
// single-clock glitches and adds 2 clocks of latency to both edges.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   pwm_in - asynchronous PWM line
//   s      - synchronized (and optionally filtered) line level
//   rise   - s is 1 and was 0 on the previous clock
//   fall   - s is 0 and was 1 on the previous clock
module pwm_in_sync
  import pwm_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  logic dly1;
  logic dly2;
  logic filt;

  // The majority result is registered so both edges are delayed by exactly
  // two clocks; a clean pulse therefore keeps its measured width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dly1 <= 1'b0;
      dly2 <= 1'b0;
      filt <= 1'b0;
    end else begin
      dly1 <= sync2;
      dly2 <= dly1;
      filt <= (sync2 & dly1) | (sync2 & dly2) | (dly1 & dly2);
    end
  end

  assign s = filt;
`else
  assign s = sync2;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= s;
    end
  end

  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder
// Receive-side counterpart of the 8-bit PWM generator. Measures the high
// time and the period between consecutive rising edges of a sampled PWM
// line, reports the recovered duty code with a one-cycle strobe, flags
// periods that differ from PERIOD and declares a stuck line when no rising
// edge arrives for TIMEOUT clocks. The partial period seen after reset or
// after a stuck report is never reported.
// Optional build macro PWM_DEC_GLITCH_FILTER_EN (see pwm_in_sync) enables
// a majority glitch filter on the input; strobes then arrive 2 clocks later.
// Parameters:
//   WIDTH   - duty code width
//   PERIOD  - expected period in clocks
//   TIMEOUT - clocks without a rising edge before stuck (> PERIOD)
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous, active-high
//   pwm_in     - asynchronous PWM line
//   duty_out   - last measured high time, saturated to 2^WIDTH-1
//   duty_valid - one-cycle strobe when duty_out updates
//   period_err - last measured period differed from PERIOD
//   stuck      - no rising edge for TIMEOUT clocks, held until next rise
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int WIDTH   = DUTY_W,
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             duty_valid,
  output logic             period_err,
  output logic             stuck
);

  localparam logic [WIDTH+1:0] PER_NOM  = (WIDTH+2)'(PERIOD);
  localparam logic [WIDTH+1:0] PER_LAST = (WIDTH+2)'(TIMEOUT - 1);
  localparam logic [WIDTH:0]   HI_SAT   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   HI_MAX   = {(WIDTH+1){1'b1}};

  logic s;
  logic rise;
  logic fall;

  pwm_state_t       state;
  logic [WIDTH+1:0] per_cnt;
  logic [WIDTH:0]   hi_cnt;

  pwm_in_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  // Measurement FSM and output registers. A rise always has priority over
  // the timeout so a period that ends exactly at the limit is still reported
  // as a normal measurement. The rise cycle itself is the first clock of the
  // new period and the first high clock, hence the restart values of 1.
  // The timeout fires on the clock where per_cnt would reach TIMEOUT, so a
  // line stuck in IDLE is reported every TIMEOUT clocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      duty_out   <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (rise) begin
        if (state == LOW) begin
          duty_out   <= (hi_cnt > HI_SAT) ? {WIDTH{1'b1}} : hi_cnt[WIDTH-1:0];
          period_err <= (per_cnt != PER_NOM);
          duty_valid <= 1'b1;
        end
        stuck   <= 1'b0;
        state   <= HIGH;
        per_cnt <= {{(WIDTH+1){1'b0}}, 1'b1};
        hi_cnt  <= {{WIDTH{1'b0}}, 1'b1};
      end else if (per_cnt >= PER_LAST) begin
        stuck      <= 1'b1;
        duty_valid <= 1'b1;
        duty_out   <= s ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        period_err <= 1'b1;
        state      <= IDLE;
        per_cnt    <= '0;
        hi_cnt     <= '0;
      end else begin
        per_cnt <= per_cnt + 1'b1;
        case (state)
          HIGH: begin
            if (s && (hi_cnt != HI_MAX)) begin
              hi_cnt <= hi_cnt + 1'b1;
            end
            if (fall) begin
              state <= LOW;
            end
          end
          LOW:     state <= LOW;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
// Directed self-checking bench for pwm_decoder (default build, glitch
// filter macro PWM_DEC_GLITCH_FILTER_EN undefined). A behavioural copy of
// the 8-bit PWM generator or hand-driven levels feed pwm_in; every clock
// the bench records duty_valid strobes and the values reported with them,
// and the directed steps compare those records with hand-computed values.
// Ports: none (top-level bench).
module tb_pwm_decoder;

  logic       clock;
  logic       reset;
  logic       pwm_in;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       period_err;
  logic       stuck;

  int n_checks;
  int n_errors;

  int cyc;
  int gen_ph;
  int gen_code;
  bit manual_mode;
  bit manual_level;
  bit glitch_en;
  int glitch_ph;

  int       strobe_cnt;
  int       strobe_gap;
  int       last_strobe_cyc;
  int       run_len;
  int       max_run;
  logic     last_valid;
  logic [7:0] last_duty;
  logic     last_err;
  logic     last_stuck;

  pwm_decoder dut (
    .clock      (clock),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advances n clocks. Outputs are sampled 1 time unit after each rising
  // edge, then the next pwm_in level is driven from the generator model or
  // the manual level.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      last_valid = duty_valid;
      if (duty_valid === 1'b1) begin
        strobe_cnt      = strobe_cnt + 1;
        strobe_gap      = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        last_duty       = duty_out;
        last_err        = period_err;
        last_stuck      = stuck;
        run_len         = run_len + 1;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (manual_mode) begin
        pwm_in = manual_level;
      end else begin
        pwm_in = (gen_ph < gen_code) || (glitch_en && (gen_ph == glitch_ph));
        gen_ph = (gen_ph + 1) % 256;
      end
      cyc = cyc + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks = n_checks + 1;
    assert (observed === expected)
    else begin
      n_errors = n_errors + 1;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic runCode(input int code, input int n);
    manual_mode = 1'b0;
    gen_code    = code;
    strobe_cnt  = 0;
    applyStimulus(n);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    cyc             = 0;
    gen_ph          = 0;
    gen_code        = 0;
    manual_mode     = 1'b1;
    manual_level    = 1'b0;
    glitch_en       = 1'b0;
    glitch_ph       = 0;
    strobe_cnt      = 0;
    strobe_gap      = 0;
    last_strobe_cyc = 0;
    run_len         = 0;
    max_run         = 0;
    last_valid      = 1'b0;
    last_duty       = '0;
    last_err        = 1'b0;
    last_stuck      = 1'b0;
    pwm_in          = 1'b0;
    reset           = 1'b1;

    $display("[TB] reset");
    applyStimulus(4);
    checkOutput("reset_duty", duty_out, 0);
    checkOutput("reset_valid", duty_valid, 0);
    checkOutput("reset_err", period_err, 0);
    checkOutput("reset_stuck", stuck, 0);
    reset = 1'b0;
    cyc   = 0;

    $display("[TB] code 100");
    runCode(100, 1024);
    checkOutput("c100_strobes", strobe_cnt, 3);
    checkOutput("c100_duty", last_duty, 100);
    checkOutput("c100_err", last_err, 0);
    checkOutput("c100_gap", strobe_gap, 256);

    $display("[TB] codes 1, 128, 255");
    runCode(1, 512);
    checkOutput("c1_strobes", strobe_cnt, 2);
    checkOutput("c1_duty", last_duty, 1);
    checkOutput("c1_err", last_err, 0);
    runCode(128, 512);
    checkOutput("c128_duty", last_duty, 128);
    checkOutput("c128_err", last_err, 0);
    runCode(255, 512);
    checkOutput("c255_duty", last_duty, 255);
    checkOutput("c255_err", last_err, 0);

    $display("[TB] code 0 stuck low");
    runCode(0, 1024);
    checkOutput("c0_strobes", strobe_cnt, 2);
    checkOutput("c0_duty", last_duty, 0);
    checkOutput("c0_err", last_err, 1);
    checkOutput("c0_stuck_strobe", last_stuck, 1);
    checkOutput("c0_gap", strobe_gap, 512);

    $display("[TB] code 50 recovers");
    runCode(50, 3);
    checkOutput("c50_stuck_before_rise", stuck, 1);
    applyStimulus(1);
    checkOutput("c50_stuck_cleared", stuck, 0);
    strobe_cnt = 0;
    applyStimulus(508);
    checkOutput("c50_strobes", strobe_cnt, 1);
    checkOutput("c50_duty", last_duty, 50);
    checkOutput("c50_err", last_err, 0);

    $display("[TB] 40 high / 260 low");
    manual_mode = 1'b1;
    strobe_cnt  = 0;
    for (int r = 0; r < 3; r++) begin
      manual_level = 1'b1;
      applyStimulus(40);
      manual_level = 1'b0;
      applyStimulus(260);
    end
    checkOutput("m40_strobes", strobe_cnt, 3);
    checkOutput("m40_duty", last_duty, 40);
    checkOutput("m40_err", last_err, 1);
    checkOutput("m40_gap", strobe_gap, 300);

    $display("[TB] stuck high");
    strobe_cnt   = 0;
    manual_level = 1'b1;
    applyStimulus(600);
    checkOutput("hi_strobes", strobe_cnt, 2);
    checkOutput("hi_duty", last_duty, 255);
    checkOutput("hi_stuck", last_stuck, 1);
    checkOutput("hi_err", last_err, 1);

    $display("[TB] reset mid-HIGH");
    manual_level = 1'b0;
    applyStimulus(50);
    manual_level = 1'b1;
    applyStimulus(20);
    checkOutput("pre_rst_duty", duty_out, 255);
    checkOutput("pre_rst_stuck", stuck, 0);
    reset = 1'b1;
    #1;
    checkOutput("rst_duty", duty_out, 0);
    checkOutput("rst_valid", duty_valid, 0);
    checkOutput("rst_err", period_err, 0);
    checkOutput("rst_stuck", stuck, 0);
    strobe_cnt   = 0;
    manual_level = 1'b0;
    applyStimulus(3);
    checkOutput("rst_no_strobe", strobe_cnt, 0);
    reset  = 1'b0;
    gen_ph = 0;
    runCode(100, 258);
    checkOutput("post_rst_first_rise_silent", strobe_cnt, 0);
    applyStimulus(2);
    checkOutput("post_rst_strobes", strobe_cnt, 1);
    checkOutput("post_rst_duty", last_duty, 100);
    checkOutput("post_rst_err", last_err, 0);
    applyStimulus(252);

    $display("[TB] glitch in LOW");
    glitch_ph  = 200;
    glitch_en  = 1'b1;
    strobe_cnt = 0;
    applyStimulus(203);
    glitch_en = 1'b0;
    applyStimulus(1);
    checkOutput("glitch_valid", last_valid, 1);
    checkOutput("glitch_duty", last_duty, 100);
    checkOutput("glitch_err", last_err, 1);
    applyStimulus(56);
    checkOutput("after_glitch_valid", last_valid, 1);
    checkOutput("after_glitch_duty", last_duty, 1);
    checkOutput("after_glitch_err", last_err, 1);
    checkOutput("glitch_strobes", strobe_cnt, 3);

    checkOutput("strobe_width", max_run, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
